mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped 8N1 UART transmitter on the KANADE32 data-memory bus, downstream of the memory-access stage.
//  Shares the word address, write data and write enable that feed RAM. Asserts sel on an address hit so the
//  top level can steer the load data mux and gate the RAM write enable.
//  Holds stores in a small TX FIFO and serialises them onto txd.
// PARAMETERS
//  BASE_ADDR   32'hFFFF_0000  byte base of the 16-byte register window (bits [3:0] must be 0)
//  CLK_DIV     434            clocks per UART bit (>=2); 50 MHz / 115200
//  FIFO_AW     4              FIFO address width; depth = 2**FIFO_AW
// PORTS
//  clk       in   1   system clock, rising edge
//  reset_n   in   1   asynchronous, active-low reset
//  address   in   30  word address (byte address [31:2]), same net as RAM address
//  data      in   32  store data
//  wren      in   1   store strobe (already qualified with mem_write)
//  sel       out  1   combinational: address within window
//  q         out  32  read data, registered (1-cycle latency, same as RAM q)
//  txd       out  1   serial output, idle high
//  irq_empty out  1   registered: FIFO empty & FSM IDLE & CTRL.en
// BEHAVIOUR
//  Register map (byte offset from BASE_ADDR):
//   0x0 TXDATA  W: push data[7:0]. R: 0.
//   0x4 STATUS  R: [0] busy (FSM!=IDLE), [1] full, [2] empty, [3] overflow (sticky),
//               [8+:FIFO_AW+1] count. W: write 1 to bit 3 to clear overflow.
//   0x8 CTRL    R/W: [0] en (reset 1). Other bits read 0.
//   0xC         reserved. R: 0; W: ignored.
//  Reads: q <= selected register every clock while sel=1, else q <= 0. Reads have no side effects.
//   (The address bus toggles every cycle for instruction fetch.)
//  Writes: act only when wren & sel. A write outside the window is ignored.
//  Reset: txd=1, q=0, irq_empty=0, FIFO empty, overflow=0, en=1, FSM=IDLE, baud counter=0.
//   Reset is asynchronous; it aborts a frame mid-bit and txd goes high at once.
//  FIFO: synchronous, first-word fall-through to the FSM; count is 0..2**FIFO_AW.
//   A push is accepted when !full, or when a pop occurs in the same cycle (count is then unchanged).
//   Otherwise the push is dropped and overflow is set. If a W1C clear and a new overflow occur
//    in the same cycle, the bit stays set.
//   Pointers wrap modulo depth. Full/empty are derived from count.
//  FSM states: IDLE, START, DATA, STOP. The baud counter reloads CLK_DIV-1 and decrements;
//   bit_end = (counter==0). A 3-bit index selects the data bit, LSB first.
//   IDLE : txd=1. If en & !empty: pop, load shift reg, reload counter -> START.
//   START: txd=0. On bit_end -> DATA, index=0.
//   DATA : txd=shift[0]. On bit_end: shift right; if index==7 -> STOP, else index++.
//   STOP : txd=1. On bit_end: if en & !empty, pop and go -> START (no idle cycle); else -> IDLE.
//  Timing: a store at clock edge N makes the FIFO non-empty after N. The pop happens at N+1 and
//   txd falls at N+1. Each bit lasts exactly CLK_DIV clocks; a frame is 10*CLK_DIV clocks.
//  Clearing en mid-frame: the current frame completes and no further pop occurs. FIFO contents are retained.
//  txd is driven from a flop, so it is glitch-free.
// STRUCTURE
//  Shared package/header kanade32_mmio_pkg: register offsets, STATUS bit indices, FSM state
//   encodings, default BASE_ADDR.
//  One sub-module: mmio_fifo (parameterised FIFO_AW, 8-bit data, push/pop/count/full/empty).
//   The FSM, baud counter and register decode stay in mmio_uart_tx.
// TESTING (CLK_DIV=4, FIFO_AW=4)
//  1 Reset: after release, txd=1, irq_empty=1 one clock later.
//    Read STATUS -> q=32'h0000_0004 on the next clock.
//  2 Store 0x55 to TXDATA: txd=0 for 4 clocks starting one edge after the store, then 1,0,1,0,1,0,1,0
//    (4 clocks each), then stop=1. Busy is cleared 40 clocks after the pop.
//  3 With en=0, store 17 bytes: the first 16 are accepted, STATUS=32'h0000_100A (count 16, full, overflow).
//    Write 0x8 to STATUS -> overflow=0.
//    Set en=1 -> all 16 bytes are transmitted in order, with no gaps.
//  4 Store 0xA5 and 0x3C back-to-back: the second start bit falls exactly 40 clocks after the first;
//    the frames decode to A5, 3C.
//  5 Assert reset_n=0 during DATA bit 3: txd=1 in the same cycle; after release STATUS shows empty
//    and not busy.
//  6 Store to BASE_ADDR+0x10 and to 0x0000_0000: sel=0, FIFO count is unchanged, txd stays 1.

Source files
------------

// File: rtl/kanade32_mmio_pkg.sv
// Shared definitions for KANADE32 memory-mapped peripherals: register word
// offsets inside a 16-byte window, STATUS/CTRL bit positions, UART FSM
// encodings and the default window base.
package kanade32_mmio_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;

    // Word index (byte offset >> 2) inside the register window
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // STATUS bit positions
    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_COUNT_LSB = 8;

    // CTRL bit positions
    localparam int CTRL_EN = 0;

    // UART transmitter FSM encodings
    typedef logic [1:0] uart_state_t;
    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

    // True when a word address falls inside the 16-byte window at base
    function automatic logic in_window(input logic [29:0] word_addr,
                                       input logic [31:0] base);
        return word_addr[29:2] == base[31:4];
    endfunction

endpackage

// File: rtl/mmio_fifo.sv
// Synchronous first-word-fall-through byte FIFO. Storage is a plain array
// (no reset) so it maps onto distributed RAM; the head word is read
// combinationally so the consumer sees it as soon as count is non-zero.
module mmio_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    pop_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          push_accept
);

    localparam int DEPTH = 1 << AW;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          pop_ok;

    assign full        = (count_reg == (AW + 1)'(DEPTH));
    assign empty       = (count_reg == '0);
    assign count       = count_reg;
    assign pop_ok      = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken
    assign push_accept = push & (~full | pop_ok);
    assign pop_data    = mem[rd_ptr_reg];

    // Storage write; no reset so the array stays a RAM
    always_ff @(posedge clk) begin
        if (push_accept) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_accept) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_accept, pop_ok})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the KANADE32 data bus. Decodes a
// 16-byte register window, queues TXDATA stores in a FIFO and serialises
// them LSB first on txd with a CLK_DIV-clock bit period.
module mmio_uart_tx
    import kanade32_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          CLK_DIV   = 434,
    parameter int          FIFO_AW   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [29:0] address,
    input  logic [31:0] data,
    input  logic        wren,
    output logic        sel,
    output logic [31:0] q,
    output logic        txd,
    output logic        irq_empty
);

    localparam int             CW     = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  RELOAD = CW'(CLK_DIV - 1);

    // Bus decode
    logic [1:0] reg_idx;
    logic       wr_hit;
    logic       push;
    logic       ovf_clr;
    logic       ctrl_wr;

    // FIFO interface
    logic [7:0]       fifo_data;
    logic [FIFO_AW:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push_accept;
    logic             pop;

    // Architectural state
    uart_state_t      state_reg,  state_next;
    logic [CW-1:0]    cnt_reg,    cnt_next;
    logic [2:0]       idx_reg,    idx_next;
    logic [7:0]       shift_reg,  shift_next;
    logic             txd_reg,    txd_next;
    logic             ovf_reg,    ovf_next;
    logic             en_reg;
    logic [31:0]      q_reg,      q_next;
    logic             irq_empty_reg;
    logic             bit_end;
    logic [31:0]      status_word;

    // Only the low byte and two control bits of store data are meaningful
    logic unused_data;
    assign unused_data = ^{data[31:8], data[6:4], data[2:1]};

    assign sel     = in_window(address, BASE_ADDR);
    assign reg_idx = address[1:0];
    assign wr_hit  = wren & sel;
    assign push    = wr_hit & (reg_idx == REG_TXDATA);
    assign ovf_clr = wr_hit & (reg_idx == REG_STATUS) & data[STAT_OVF];
    assign ctrl_wr = wr_hit & (reg_idx == REG_CTRL);
    assign bit_end = (cnt_reg == '0);

    assign txd       = txd_reg;
    assign q         = q_reg;
    assign irq_empty = irq_empty_reg;

    mmio_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (push),
        .push_data   (data[7:0]),
        .pop         (pop),
        .pop_data    (fifo_data),
        .count       (fifo_count),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .push_accept (push_accept)
    );

    // Assemble STATUS and select the read word for the current address
    always_comb begin
        status_word                                   = '0;
        status_word[STAT_BUSY]                        = (state_reg != ST_IDLE);
        status_word[STAT_FULL]                        = fifo_full;
        status_word[STAT_EMPTY]                       = fifo_empty;
        status_word[STAT_OVF]                         = ovf_reg;
        status_word[STAT_COUNT_LSB +: FIFO_AW + 1]    = fifo_count;

        q_next = '0;
        if (sel) begin
            case (reg_idx)
                REG_STATUS: q_next = status_word;
                REG_CTRL:   q_next[CTRL_EN] = en_reg;
                default:    q_next = '0;
            endcase
        end
    end

    // Overflow is sticky; a new drop wins over a simultaneous W1C
    always_comb begin
        ovf_next = (push & ~push_accept) | (ovf_reg & ~ovf_clr);
    end

    // Transmit FSM: next state, baud counter, bit index, shifter and txd level
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        txd_next   = txd_reg;
        pop        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                txd_next = 1'b1;
                if (en_reg && !fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_data;
                    cnt_next   = RELOAD;
                    state_next = ST_START;
                    txd_next   = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_next   = RELOAD;
                    idx_next   = 3'd0;
                    state_next = ST_DATA;
                    txd_next   = shift_reg[0];
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_next   = RELOAD;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (idx_reg == 3'd7) begin
                        state_next = ST_STOP;
                        txd_next   = 1'b1;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                        txd_next = shift_reg[1];
                    end
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: begin // ST_STOP
                if (bit_end) begin
                    if (en_reg && !fifo_empty) begin
                        // Chain straight into the next start bit
                        pop        = 1'b1;
                        shift_next = fifo_data;
                        cnt_next   = RELOAD;
                        state_next = ST_START;
                        txd_next   = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                        txd_next   = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
        endcase
    end

    // State, control and output registers; reset forces txd high immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            shift_reg     <= '0;
            txd_reg       <= 1'b1;
            ovf_reg       <= 1'b0;
            en_reg        <= 1'b1;
            q_reg         <= '0;
            irq_empty_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            shift_reg     <= shift_next;
            txd_reg       <= txd_next;
            ovf_reg       <= ovf_next;
            q_reg         <= q_next;
            irq_empty_reg <= fifo_empty & (state_reg == ST_IDLE) & en_reg;
            if (ctrl_wr) begin
                en_reg <= data[CTRL_EN];
            end
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx (CLK_DIV=4, FIFO_AW=4). Stimulus pushes
// expected read words and expected transmitted bytes into queues; a read
// monitor and a serial-line receiver pop and compare independently.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE     = 32'hFFFF_0000;
    localparam logic [31:0] A_TXDATA = BASE + 32'h0;
    localparam logic [31:0] A_STATUS = BASE + 32'h4;
    localparam logic [31:0] A_CTRL   = BASE + 32'h8;
    localparam logic [31:0] A_RSVD   = BASE + 32'hC;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [29:0] address = '0;
    logic [31:0] data    = '0;
    logic        wren    = 1'b0;
    logic        sel;
    logic [31:0] q;
    logic        txd;
    logic        irq_empty;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .BASE_ADDR (BASE),
        .CLK_DIV   (4),
        .FIFO_AW   (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .data      (data),
        .wren      (wren),
        .sel       (sel),
        .q         (q),
        .txd       (txd),
        .irq_empty (irq_empty)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    logic [7:0]  tx_exp_q[$];
    int          start_q[$];
    logic        rd_issue   = 1'b0;
    logic        rd_valid_d = 1'b0;
    logic        aborted    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd_valid_d <= rd_issue;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    task automatic bus_idle();
        @(negedge clk);
        address  = '0;
        data     = '0;
        wren     = 1'b0;
        rd_issue = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] baddr, input logic [31:0] d);
        @(negedge clk);
        address  = baddr[31:2];
        data     = d;
        wren     = 1'b1;
        rd_issue = 1'b0;
    endtask

    task automatic bus_read(input string name, input logic [31:0] baddr, input logic [31:0] exp);
        @(negedge clk);
        address  = baddr[31:2];
        data     = '0;
        wren     = 1'b0;
        rd_issue = 1'b1;
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
    endtask

    task automatic wait_drain(input string name, input int limit);
        int t = 0;
        while (tx_exp_q.size() != 0 && t < limit) begin
            bus_idle();
            t++;
        end
        check(name, 32'(tx_exp_q.size()), 32'd0);
    endtask

    task automatic check_gaps(input string name, input int frames);
        check({name, "_frames"}, 32'(start_q.size()), 32'(frames));
        for (int k = 1; k < start_q.size(); k++) begin
            check(name, 32'(start_q[k] - start_q[k-1]), 32'd40);
        end
    endtask

    task automatic mon_wait(input int n);
        repeat (n) begin
            @(negedge clk);
            if (reset_n !== 1'b1) aborted = 1'b1;
        end
    endtask

    // Read monitor: q is compared one clock after each issued read
    initial begin : read_mon
        forever begin
            @(negedge clk);
            if (rd_valid_d && rd_exp_q.size() != 0) begin
                check(rd_name_q.pop_front(), q, rd_exp_q.pop_front());
            end
        end
    end

    // Serial receiver: detects the start edge, samples each bit mid-period
    initial begin : uart_mon
        logic [7:0] b;
        logic       sb;
        logic       pb;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && txd === 1'b0) begin
                aborted = 1'b0;
                start_q.push_back(cyc);
                mon_wait(2);
                sb = txd;
                for (int k = 0; k < 8; k++) begin
                    mon_wait(4);
                    b[k] = txd;
                end
                mon_wait(4);
                pb = txd;
                if (!aborted) begin
                    check("start_bit", 32'(sb), 32'd0);
                    check("stop_bit", 32'(pb), 32'd1);
                    if (tx_exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got %02h expected none", b);
                    end else begin
                        check("tx_byte", 32'(b), 32'(tx_exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;

        // 1: reset state
        repeat (3) @(negedge clk);
        check("rst_q", q, 32'd0);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_irq", 32'(irq_empty), 32'd0);
        reset_n = 1'b1;
        #1 check("rel_txd", 32'(txd), 32'd1);
        @(negedge clk);
        check("rel_irq", 32'(irq_empty), 32'd1);
        bus_read("t1_status", A_STATUS, 32'h0000_0004);
        bus_read("t1_ctrl", A_CTRL, 32'h0000_0001);
        bus_idle();

        // 2: single frame 0x55 with exact start timing and busy duration
        tx_exp_q.push_back(8'h55);
        bus_write(A_TXDATA, 32'h0000_0055);
        bus_idle();
        n = cyc;
        check("t2_txd_before", 32'(txd), 32'd1);
        bus_idle();
        check("t2_txd_start", 32'(txd), 32'd0);
        while (cyc < n + 39) bus_idle();
        bus_read("t2_busy_last", A_STATUS, 32'h0000_0005);
        bus_read("t2_busy_clr", A_STATUS, 32'h0000_0004);
        bus_idle();
        wait_drain("t2_drain", 60);

        // 3: fill with en=0, overflow, W1C clear, then burst without gaps
        bus_write(A_CTRL, 32'h0);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) tx_exp_q.push_back(8'(8'h10 + i));
            bus_write(A_TXDATA, 32'(8'h10 + i));
        end
        bus_read("t3_full", A_STATUS, 32'h0000_100A);
        bus_write(A_STATUS, 32'h0000_0008);
        bus_read("t3_ovf_clr", A_STATUS, 32'h0000_1002);
        bus_read("t3_ctrl0", A_CTRL, 32'h0);
        bus_read("t3_txdata", A_TXDATA, 32'h0);
        bus_idle();
        check("t3_txd_held", 32'(txd), 32'd1);
        check("t3_irq_en0", 32'(irq_empty), 32'd0);
        start_q.delete();
        bus_write(A_CTRL, 32'h1);
        wait_drain("t3_drain", 16 * 40 + 60);
        check_gaps("t3_gap", 16);

        // 4: back-to-back stores chain frames exactly 40 clocks apart
        repeat (5) bus_idle();
        start_q.delete();
        tx_exp_q.push_back(8'hA5);
        tx_exp_q.push_back(8'h3C);
        bus_write(A_TXDATA, 32'h0000_00A5);
        bus_write(A_TXDATA, 32'h0000_003C);
        wait_drain("t4_drain", 140);
        check_gaps("t4_gap", 2);

        // 5: asynchronous reset during data bit 3 of 0xC3
        repeat (5) bus_idle();
        bus_write(A_TXDATA, 32'h0000_00C3);
        bus_idle();
        n = cyc;
        while (cyc < n + 18) bus_idle();
        check("t5_bit3", 32'(txd), 32'd0);
        reset_n = 1'b0;
        #1 check("t5_rst_txd", 32'(txd), 32'd1);
        bus_idle();
        bus_idle();
        reset_n = 1'b1;
        repeat (45) bus_idle();
        check("t5_irq", 32'(irq_empty), 32'd1);
        bus_read("t5_status", A_STATUS, 32'h0000_0004);

        // 6: out-of-window and reserved writes are ignored
        bus_write(A_CTRL, 32'h0);
        bus_write(A_TXDATA, 32'h0000_005A);
        #1 check("t6_sel_hit", 32'(sel), 32'd1);
        bus_write(BASE + 32'h10, 32'h0000_0077);
        #1 check("t6_sel_above", 32'(sel), 32'd0);
        bus_write(32'h0000_0000, 32'h0000_0066);
        #1 check("t6_sel_zero", 32'(sel), 32'd0);
        bus_write(A_RSVD, 32'hFFFF_FFFF);
        bus_read("t6_status", A_STATUS, 32'h0000_0100);
        bus_read("t6_rsvd", A_RSVD, 32'h0);
        bus_read("t6_outside", BASE + 32'h10, 32'h0);
        repeat (8) bus_idle();
        check("t6_txd_idle", 32'(txd), 32'd1);
        tx_exp_q.push_back(8'h5A);
        bus_write(A_CTRL, 32'h1);
        wait_drain("t6_drain", 80);

        repeat (4) bus_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
